// File: rtl/reg_wb_arbiter.sv
// Round-robin arbiter sharing one register-file write port among NREQ
// write-back sources, with a registered output stage that doubles as a bypass.
module reg_wb_arbiter #(
   parameter int NREQ = 3,
   parameter int XLEN = 32,
   parameter int AW   = 5
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 hold,
   input  logic [NREQ-1:0]      req_valid,
   output logic [NREQ-1:0]      req_ready,
   input  logic [NREQ*AW-1:0]   req_rd,
   input  logic [NREQ*XLEN-1:0] req_data,
   output logic [AW-1:0]        Rd,
   output logic [XLEN-1:0]      WRd,
   output logic                 WrReg,
   output logic                 fwd_valid,
   output logic [AW-1:0]        fwd_rd,
   output logic [XLEN-1:0]      fwd_data,
   output logic [2:0]           grant_idx
);

   logic [2:0]      ptr;
   logic [2:0]      win;
   logic            found;
   logic            fire;
   logic [AW-1:0]   win_rd;
   logic [XLEN-1:0] win_data;

   // Two passes give the rotated scan: indices at/after ptr, then wrap.
   always_comb begin
      req_ready = '0;
      win       = '0;
      found     = 1'b0;
      win_rd    = '0;
      win_data  = '0;
      for (int i = 0; i < NREQ; i++) begin
         if (!found && req_valid[i] && 3'(i) >= ptr) begin
            found        = 1'b1;
            win          = 3'(i);
            win_rd       = req_rd[i*AW +: AW];
            win_data     = req_data[i*XLEN +: XLEN];
            req_ready[i] = 1'b1;
         end
      end
      for (int i = 0; i < NREQ; i++) begin
         if (!found && req_valid[i] && 3'(i) < ptr) begin
            found        = 1'b1;
            win          = 3'(i);
            win_rd       = req_rd[i*AW +: AW];
            win_data     = req_data[i*XLEN +: XLEN];
            req_ready[i] = 1'b1;
         end
      end
      if (hold || !rst_n) begin
         req_ready = '0;
      end
   end

   assign fire = |req_ready;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         WrReg     <= 1'b0;
         Rd        <= '0;
         WRd       <= '0;
         grant_idx <= '0;
         ptr       <= '0;
      end else begin
         WrReg <= fire;
         if (fire) begin
            Rd        <= win_rd;
            WRd       <= win_data;
            grant_idx <= win;
            ptr       <= (win == 3'(NREQ-1)) ? 3'd0 : win + 3'd1;
         end
      end
   end

   assign fwd_valid = WrReg && (Rd != '0);
   assign fwd_rd    = Rd;
   assign fwd_data  = WRd;

endmodule

// File: tb/tb_reg_wb_arbiter.sv
// Scoreboard bench for reg_wb_arbiter: a reference arbiter predicts grants,
// expected writes are queued at grant time and popped one cycle later.
module tb_reg_wb_arbiter;

   localparam int NREQ = 3;
   localparam int XLEN = 32;
   localparam int AW   = 5;

   logic                 clk;
   logic                 rst_n;
   logic                 hold;
   logic [NREQ-1:0]      req_valid;
   logic [NREQ-1:0]      req_ready;
   logic [NREQ*AW-1:0]   req_rd;
   logic [NREQ*XLEN-1:0] req_data;
   logic [AW-1:0]        Rd;
   logic [XLEN-1:0]      WRd;
   logic                 WrReg;
   logic                 fwd_valid;
   logic [AW-1:0]        fwd_rd;
   logic [XLEN-1:0]      fwd_data;
   logic [2:0]           grant_idx;

   typedef struct {
      logic [AW-1:0]   rd;
      logic [XLEN-1:0] data;
      logic [2:0]      idx;
   } wr_t;

   wr_t sb[$];
   int  n_chk;
   int  n_pass;
   int  mptr;
   logic [AW-1:0]   last_rd;
   logic [XLEN-1:0] last_data;
   logic [2:0]      last_idx;

   reg_wb_arbiter #(.NREQ(NREQ), .XLEN(XLEN), .AW(AW)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .hold      (hold),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_rd    (req_rd),
      .req_data  (req_data),
      .Rd        (Rd),
      .WRd       (WRd),
      .WrReg     (WrReg),
      .fwd_valid (fwd_valid),
      .fwd_rd    (fwd_rd),
      .fwd_data  (fwd_data),
      .grant_idx (grant_idx)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got,
                        input logic [63:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask

   function automatic int model_win(input logic [NREQ-1:0] v,
                                    input logic h, input int p);
      int idx;
      if (h) return -1;
      for (int k = 0; k < NREQ; k++) begin
         idx = (p + k) % NREQ;
         if (v[idx]) return idx;
      end
      return -1;
   endfunction

   task automatic set_req(input int i, input logic [AW-1:0] rd,
                          input logic [XLEN-1:0] data);
      req_rd[i*AW +: AW]       = rd;
      req_data[i*XLEN +: XLEN] = data;
   endtask

   // Inputs are driven at the negedge; one cycle is checked and we
   // return at the following negedge.
   task automatic cycle(input string tag);
      int  w;
      wr_t e;
      logic [NREQ-1:0] exp_rdy;
      #1;
      w = model_win(req_valid, hold, mptr);
      exp_rdy = '0;
      if (w >= 0) begin
         exp_rdy[w] = 1'b1;
         e.rd   = req_rd[w*AW +: AW];
         e.data = req_data[w*XLEN +: XLEN];
         e.idx  = 3'(w);
         sb.push_back(e);
         mptr = (w + 1) % NREQ;
      end
      check({tag, ".ready"}, 64'(req_ready), 64'(exp_rdy));
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
         e = sb.pop_front();
         last_rd   = e.rd;
         last_data = e.data;
         last_idx  = e.idx;
         check({tag, ".wr"},   64'(WrReg), 64'd1);
         check({tag, ".rd"},   64'(Rd), 64'(e.rd));
         check({tag, ".data"}, 64'(WRd), 64'(e.data));
         check({tag, ".gidx"}, 64'(grant_idx), 64'(e.idx));
         check({tag, ".fwdv"}, 64'(fwd_valid), 64'(e.rd != '0));
         check({tag, ".fwdd"}, 64'({fwd_rd, fwd_data}),
               64'({e.rd, e.data}));
      end else begin
         check({tag, ".idle_wr"}, 64'(WrReg), 64'd0);
         check({tag, ".idle_fv"}, 64'(fwd_valid), 64'd0);
         check({tag, ".keep"}, 64'({Rd, WRd}),
               64'({last_rd, last_data}));
         check({tag, ".keep_g"}, 64'(grant_idx), 64'(last_idx));
      end
      @(negedge clk);
   endtask

   initial begin
      n_chk = 0;
      n_pass = 0;
      mptr = 0;
      last_rd = '0;
      last_data = '0;
      last_idx = '0;
      hold = 1'b0;
      req_valid = '1;
      req_rd = '0;
      req_data = '0;
      set_req(0, 5'd1, 32'h1111_0000);
      set_req(1, 5'd2, 32'h2222_0000);
      set_req(2, 5'd3, 32'h3333_0000);
      rst_n = 1'b0;

      repeat (2) @(negedge clk);
      check("rst.ready", 64'(req_ready), 64'd0);
      check("rst.wr", 64'(WrReg), 64'd0);
      check("rst.out", 64'({Rd, WRd}), 64'd0);
      check("rst.gidx", 64'(grant_idx), 64'd0);
      rst_n = 1'b1;

      // Continuous traffic, then two more grants (0,1)
      for (int c = 0; c < 8; c++) begin
         set_req(c % NREQ, 5'(c + 4), 32'hA000_0000 + 32'(c));
         cycle("rr");
      end

      req_valid = 3'b100;
      set_req(2, 5'd7, 32'hDEAD_BEEF);
      cycle("only2");

      req_valid = 3'b010;
      set_req(1, 5'd0, 32'h0000_1234);
      cycle("x0");

      req_valid = 3'b111;
      set_req(0, 5'd9, 32'h0BAD_0000);
      cycle("pre_hold");
      hold = 1'b1;
      repeat (3) cycle("hold");
      hold = 1'b0;
      repeat (2) cycle("resume");

      // Two requesters hitting the same destination back to back
      set_req(0, 5'd12, 32'hC0C0_0001);
      set_req(1, 5'd12, 32'hC0C0_0002);
      set_req(2, 5'd12, 32'hC0C0_0003);
      repeat (3) cycle("same_rd");

      for (int c = 0; c < 40; c++) begin
         req_valid = NREQ'($urandom_range(0, 7));
         hold = ($urandom_range(0, 4) == 0);
         for (int i = 0; i < NREQ; i++)
            set_req(i, AW'($urandom), $urandom);
         cycle("rand");
      end
      hold = 1'b0;

      req_valid = 3'b111;
      cycle("pre_rst");
      cycle("pre_rst2");
      #2;
      check("mrst.wr_before", 64'(WrReg), 64'd1);
      rst_n = 1'b0;
      #1;
      check("mrst.wr", 64'(WrReg), 64'd0);
      check("mrst.out", 64'({Rd, WRd}), 64'd0);
      check("mrst.ready", 64'(req_ready), 64'd0);
      sb.delete();
      mptr = 0;
      last_rd = '0;
      last_data = '0;
      last_idx = '0;
      @(negedge clk);
      rst_n = 1'b1;
      repeat (2) cycle("post_rst");

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout: got running expected finished");
      $fatal(1);
   end

endmodule

// File: doc/reg_wb_arbiter.md
Name: reg_wb_arbiter

Overview:
Shares the single register-file write port between NREQ write-back requesters, such as ALU, load unit and multiply/divide unit. Arbitration is round-robin over valid/ready handshakes. The winning request goes into one output register stage that drives the register file's Rd/WRd/WrReg inputs directly. That same output stage is exported as a forwarding source so readers can bypass the in-flight write.

Parameters:
NREQ, 3, number of write-back requesters (2..8)
XLEN, 32, data width
AW, 5, register index width (32 architectural registers, x0 hardwired zero)

Ports:
clk  input  1  clock, all state updates on rising edge
rst_n  input  1  asynchronous active-low reset
hold  input  1  when 1, no grants are issued this cycle
req_valid  input  NREQ  request i presents a write
req_ready  output  NREQ  request i is granted this cycle (one-hot or zero)
req_rd  input  NREQ*AW  destination index of request i, slice [i*AW +: AW]
req_data  input  NREQ*XLEN  write data of request i, slice [i*XLEN +: XLEN]
Rd  output  AW  register-file write index (registered)
WRd  output  XLEN  register-file write data (registered)
WrReg  output  1  register-file write enable (registered)
fwd_valid  output  1  equals WrReg && Rd != 0
fwd_rd  output  AW  equals Rd
fwd_data  output  XLEN  equals WRd
grant_idx  output  3  index of last accepted requester (registered, debug)

Behaviour:
- Reset (rst_n low, asynchronous): WrReg=0, Rd=0, WRd=0, grant_idx=0, round-robin pointer ptr=0. req_ready is 0 while rst_n is low.
- Arbitration is combinational within the cycle:
  - Scan indices ptr, ptr+1, …, NREQ-1, 0, …, ptr-1.
  - The first i with req_valid[i]=1 gets req_ready[i]=1. All other ready bits are 0.
  - If hold=1 or no valid request, req_ready=0.
- A handshake completes when req_valid[i] && req_ready[i] at a rising edge.
- On handshake with winner i at edge t:
  - Rd <= req_rd[i], WRd <= req_data[i], WrReg <= 1, grant_idx <= i.
  - ptr <= (i+1) mod NREQ.
  - Latency is exactly 1 cycle from handshake to WrReg.
- With no handshake at an edge: WrReg <= 0. Rd and WRd hold their previous values. ptr is unchanged.
- Writes to x0 are accepted normally and consume the grant and the pointer advance. They produce WrReg=1 with Rd=0, which the register file ignores. fwd_valid=0 for these writes.
- The downstream port has no back-pressure. A write can be accepted every cycle, giving a sustained throughput of 1 write/cycle.
- Requesters must hold req_valid, req_rd and req_data stable until ready. The block does not buffer unaccepted requests.
- hold asserted while a write is in the output stage: that write still appears (WrReg=1) in the following cycle. Only new grants are blocked.
- Two requesters may target the same Rd in consecutive cycles. They are written in grant order, and the later one wins in the register file.
- Reset mid-operation: the pending output write is discarded (WrReg=0 immediately). No grant is issued until after rst_n deasserts.
- Fairness: a continuously valid requester is granted within NREQ grants.

Test Plan:
1. Reset with all req_valid=1 -> req_ready=0 during reset and WrReg=0. First cycle after release: req_ready=3'b001. Next cycle: WrReg=1 with Rd/WRd from req 0.
2. NREQ=3, all valid continuously for 6 cycles -> grants 0,1,2,0,1,2. WrReg=1 on every cycle from the 2nd onward. grant_idx follows 0,1,2,… one cycle late.
3. Only req 2 valid (rd=7, data=0xDEADBEEF) after grants to 0 and 1 -> req_ready=3'b100. Next cycle: Rd=7, WRd=0xDEADBEEF, fwd_valid=1. ptr becomes 0.
4. req 1 valid with rd=0, data=0x1234 -> handshake occurs. Next cycle: WrReg=1, Rd=0, fwd_valid=0. ptr advances to 2.
5. hold=1 for 3 cycles with all requests valid -> req_ready=0 and WrReg=0 from the 2nd hold cycle on. The in-flight write completes. After release, arbitration resumes from the unchanged ptr.
6. Assert rst_n=0 asynchronously mid-cycle while WrReg=1 -> WrReg, Rd and WRd go to 0 without waiting for a clk edge. ptr=0 after release.
